// File: rtl/puf_ctrl_pkg.sv
// Shared state encoding and default timing constants for the PUF CRP sequencer.
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PRST  = 3'd2,
        ST_GAP   = 3'd3,
        ST_EVAL  = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    localparam int unsigned DEF_C_BITS       = 8;
    localparam int unsigned DEF_PHASE_CYC    = 10;
    localparam int unsigned DEF_WAIT_PER_BIT = 16;

    // Bits needed to count down from max(a,b)-1 to zero.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer bringing the asynchronous PUF response into the clk domain.
module puf_resp_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_crp_sequencer.sv
// Sweeps a challenge range through reset/launch/evaluate phases of a PUF and
// presents each challenge-response pair on a valid/ready interface.
module puf_crp_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int unsigned C_BITS    = DEF_C_BITS,
    parameter int unsigned PHASE_CYC = DEF_PHASE_CYC,
    parameter int unsigned WAIT_CYC  = DEF_WAIT_PER_BIT * C_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [C_BITS-1:0] start_chal,
    input  logic [C_BITS-1:0] last_chal,
    output logic              puf_reset,
    output logic              puf_enable,
    output logic [C_BITS-1:0] challenge,
    input  logic              puf_resp,
    output logic              crp_valid,
    input  logic              crp_ready,
    output logic [C_BITS-1:0] crp_challenge,
    output logic              crp_resp,
    output logic              busy,
    output logic              done
);

    localparam int unsigned     CNT_W      = cnt_width(PHASE_CYC, WAIT_CYC);
    localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYC - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [C_BITS-1:0] last_reg;
    logic              resp_sync;
    logic              phase_end;

    puf_resp_sync u_resp_sync (
        .clk   (clk),
        .reset (reset),
        .d     (puf_resp),
        .q     (resp_sync)
    );

    assign phase_end = (cnt == '0);

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            last_reg      <= '0;
            challenge     <= '0;
            puf_reset     <= 1'b0;
            puf_enable    <= 1'b0;
            crp_valid     <= 1'b0;
            crp_challenge <= '0;
            crp_resp      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            // Abort wins over everything, including a same-cycle handshake.
            if (abort && (state != ST_IDLE)) begin
                state      <= ST_IDLE;
                puf_reset  <= 1'b0;
                puf_enable <= 1'b0;
                crp_valid  <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            challenge <= start_chal;
                            last_reg  <= last_chal;
                            cnt       <= PHASE_LOAD;
                            busy      <= 1'b1;
                            state     <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        if (phase_end) begin
                            puf_reset <= 1'b1;
                            cnt       <= PHASE_LOAD;
                            state     <= ST_PRST;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_PRST: begin
                        if (phase_end) begin
                            puf_reset <= 1'b0;
                            cnt       <= PHASE_LOAD;
                            state     <= ST_GAP;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (phase_end) begin
                            puf_enable <= 1'b1;
                            cnt        <= WAIT_LOAD;
                            state      <= ST_EVAL;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_EVAL: begin
                        // Capture happens on the edge that closes the last EVAL cycle.
                        if (phase_end) begin
                            crp_resp      <= resp_sync;
                            crp_challenge <= challenge;
                            crp_valid     <= 1'b1;
                            puf_enable    <= 1'b0;
                            cnt           <= PHASE_LOAD;
                            state         <= ST_OUT;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_OUT: begin
                        if (crp_ready) begin
                            crp_valid <= 1'b0;
                            if (challenge == last_reg) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                challenge <= challenge + C_BITS'(1);
                                cnt       <= PHASE_LOAD;
                                state     <= ST_SETUP;
                            end
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        puf_reset  <= 1'b0;
                        puf_enable <= 1'b0;
                        crp_valid  <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Scoreboard bench for puf_crp_sequencer with short phases (period 11 cycles).
module tb_puf_crp_sequencer;

    localparam int unsigned C_BITS    = 8;
    localparam int unsigned PHASE_CYC = 2;
    localparam int unsigned WAIT_CYC  = 4;
    localparam int          PERIOD    = 3 * PHASE_CYC + WAIT_CYC + 1;

    typedef struct packed {
        logic [7:0] chal;
        logic       resp;
    } crp_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [C_BITS-1:0] start_chal;
    logic [C_BITS-1:0] last_chal;
    logic              puf_reset;
    logic              puf_enable;
    logic [C_BITS-1:0] challenge;
    logic              puf_resp;
    logic              crp_valid;
    logic              crp_ready;
    logic [C_BITS-1:0] crp_challenge;
    logic              crp_resp;
    logic              busy;
    logic              done;

    bit   parity_mode;
    logic puf_const;
    crp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   cyc;

    puf_crp_sequencer #(
        .C_BITS    (C_BITS),
        .PHASE_CYC (PHASE_CYC),
        .WAIT_CYC  (WAIT_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .start_chal    (start_chal),
        .last_chal     (last_chal),
        .puf_reset     (puf_reset),
        .puf_enable    (puf_enable),
        .challenge     (challenge),
        .puf_resp      (puf_resp),
        .crp_valid     (crp_valid),
        .crp_ready     (crp_ready),
        .crp_challenge (crp_challenge),
        .crp_resp      (crp_resp),
        .busy          (busy),
        .done          (done)
    );

    // Behavioural PUF: parity of the applied challenge, or a fixed level.
    assign puf_resp = parity_mode ? ^challenge : puf_const;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic model_resp(input logic [7:0] c);
        return parity_mode ? ^c : puf_const;
    endfunction

    task automatic run_sweep(input logic [7:0] s, input logic [7:0] l, input bit rand_ready,
                             input bit chk_spacing, input bit inject_start, input int budget);
        logic [7:0] c;
        logic [7:0] d;
        int         n;
        int         k;
        int         prev;
        int         dones;
        crp_t       e;
        d = l - s;
        n = int'(d) + 1;
        c = s;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({c, model_resp(c)});
            c = c + 8'd1;
        end
        @(negedge clk);
        start = 1'b1; start_chal = s; last_chal = l;
        prev = cyc;
        @(negedge clk);
        start = 1'b0; start_chal = ~s; last_chal = ~l;
        k = 0; dones = 0;
        while (exp_q.size() > 0 && k < budget) begin
            crp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject_start && k == 5) begin
                start = 1'b1; start_chal = 8'h80; last_chal = 8'h80;
            end else begin
                start = 1'b0;
            end
            if (done) dones++;
            if (crp_valid && crp_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (crp_challenge !== e.chal || crp_resp !== e.resp) begin
                    n_fail++;
                    $display("FAIL crp_data: got chal=%02h resp=%b, expected chal=%02h resp=%b",
                             crp_challenge, crp_resp, e.chal, e.resp);
                end
                if (chk_spacing) begin
                    n_checks++;
                    if (cyc - prev != PERIOD) begin
                        n_fail++;
                        $display("FAIL crp_spacing: got %0d cycles, expected %0d", cyc - prev, PERIOD);
                    end
                    prev = cyc;
                end
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sweep_timeout: %0d CRPs still outstanding after %0d cycles", exp_q.size(), k);
            exp_q.delete();
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end else if (done !== 1'b1 || busy !== 1'b0 || dones != 0) begin
            n_fail++;
            $display("FAIL sweep_done: got done=%b busy=%b early_dones=%0d, expected done=1 busy=0 early_dones=0",
                     done, busy, dones);
        end
        crp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_width: got done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_checks++;
        if ({puf_reset, puf_enable, crp_valid, busy, done, crp_resp} !== 6'b0 ||
            challenge !== 8'h00 || crp_challenge !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got rst=%b en=%b val=%b busy=%b done=%b resp=%b chal=%02h crpc=%02h, expected all 0",
                     puf_reset, puf_enable, crp_valid, busy, done, crp_resp, challenge, crp_challenge);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || crp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b, expected 0 0", busy, crp_valid);
        end
    endtask

    task automatic test_basic();
        parity_mode = 1'b0; puf_const = 1'b1;
        run_sweep(8'h00, 8'h03, 1'b0, 1'b1, 1'b1, 200);
    endtask

    task automatic test_wrap();
        parity_mode = 1'b1;
        run_sweep(8'hFE, 8'h01, 1'b0, 1'b1, 1'b0, 200);
    endtask

    task automatic test_full_sweep();
        parity_mode = 1'b1;
        run_sweep(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 20000);
    endtask

    task automatic test_backpressure();
        crp_t e;
        int   k;
        parity_mode = 1'b0; puf_const = 1'b1;
        exp_q.push_back({8'h10, 1'b1});
        e = exp_q[0];
        crp_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; start_chal = 8'h10; last_chal = 8'h10;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!crp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        // Response input flips while the CRP is held; the presented value must not.
        puf_const = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (crp_valid !== 1'b1 || crp_challenge !== e.chal || crp_resp !== e.resp || puf_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_out[%0d]: got val=%b chal=%02h resp=%b en=%b, expected 1 %02h %b 0",
                         i, crp_valid, crp_challenge, crp_resp, puf_enable, e.chal, e.resp);
            end
            @(negedge clk);
        end
        crp_ready = 1'b1;
        e = exp_q.pop_front();
        n_checks++;
        if (crp_valid !== 1'b1 || crp_challenge !== e.chal || crp_resp !== e.resp) begin
            n_fail++;
            $display("FAIL hold_release: got val=%b chal=%02h resp=%b, expected 1 %02h %b",
                     crp_valid, crp_challenge, crp_resp, e.chal, e.resp);
        end
        @(negedge clk);
        crp_ready = 1'b0;
        n_checks++;
        if (crp_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got val=%b done=%b busy=%b, expected 0 1 0", crp_valid, done, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_width: got done=%b, expected 0", done);
        end
    endtask

    task automatic test_abort();
        int k;
        parity_mode = 1'b1; crp_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; start_chal = 8'h20; last_chal = 8'h25;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!puf_enable && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_checks++;
        if (puf_enable !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL eval_second_cycle: got en=%b busy=%b, expected 1 1", puf_enable, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({busy, puf_enable, puf_reset, crp_valid, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b en=%b rst=%b val=%b done=%b, expected all 0",
                     busy, puf_enable, puf_reset, crp_valid, done);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_checks++;
            if (crp_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet[%0d]: got val=%b done=%b busy=%b, expected 0 0 0",
                         i, crp_valid, done, busy);
            end
        end
        run_sweep(8'h30, 8'h31, 1'b0, 1'b1, 1'b0, 200);
        // Abort coinciding with a handshake on the final CRP.
        crp_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; start_chal = 8'h40; last_chal = 8'h40;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!crp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        crp_ready = 1'b1; abort = 1'b1;
        @(negedge clk);
        crp_ready = 1'b0; abort = 1'b0;
        n_checks++;
        if (crp_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_vs_handshake: got val=%b done=%b busy=%b, expected 0 0 0", crp_valid, done, busy);
        end
    endtask

    task automatic test_reset_mid_out();
        int k;
        parity_mode = 1'b0; puf_const = 1'b1; crp_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; start_chal = 8'h5A; last_chal = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!crp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (crp_valid !== 1'b1 || crp_resp !== 1'b1 || crp_challenge !== 8'h5A) begin
            n_fail++;
            $display("FAIL pre_reset_out: got val=%b resp=%b chal=%02h, expected 1 1 5a", crp_valid, crp_resp, crp_challenge);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({puf_reset, puf_enable, crp_valid, busy, done, crp_resp} !== 6'b0 ||
            challenge !== 8'h00 || crp_challenge !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got rst=%b en=%b val=%b busy=%b done=%b resp=%b chal=%02h crpc=%02h, expected all 0",
                     puf_reset, puf_enable, crp_valid, busy, done, crp_resp, challenge, crp_challenge);
        end
        start = 1'b1; start_chal = 8'h11; last_chal = 8'h11;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || challenge !== 8'h00) begin
            n_fail++;
            $display("FAIL start_in_reset: got busy=%b chal=%02h, expected 0 00", busy, challenge);
        end
        @(negedge clk);
        reset = 1'b0; start_chal = 8'h22; last_chal = 8'h22;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || challenge !== 8'h22) begin
            n_fail++;
            $display("FAIL first_start_after_reset: got busy=%b chal=%02h, expected 1 22", busy, challenge);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cleanup_abort: got busy=%b, expected 0", busy);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        start_chal = '0; last_chal = '0; crp_ready = 1'b0;
        parity_mode = 1'b0; puf_const = 1'b0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_abort();
        test_full_sweep();
        test_reset_mid_out();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
